write_buffer: RTL and testbench
===============================

WRITE_BUFFER -- requirements
Module: write_buffer

Interface
REQ-001 SHALL have parameter DEPTH, default 4, meaning number of line entries (power of two, 2..8).
REQ-002 SHALL have parameter ADDR_W, default 28, meaning line address width.
REQ-003 SHALL have parameter LINE_W, default 128, meaning line data width.
REQ-004 SHALL use one clock and a synchronous, active-high reset; no other clock or reset exists.
REQ-005 clk  in  1  sole clock, rising edge.
REQ-006 proc_reset  in  1  synchronous active-high reset.
REQ-007 cache_read  in  1  cache line-read request, held until cache_ready.
REQ-008 cache_write  in  1  cache line-writeback request, held until cache_ready.
REQ-009 cache_addr  in  ADDR_W  line address of the request.
REQ-010 cache_wdata  in  LINE_W  writeback line data.
REQ-011 cache_rdata  out  LINE_W  read-response line; valid while cache_ready=1.
REQ-012 cache_ready  out  1  single-cycle completion pulse to the cache.
REQ-013 mem_read / mem_write  out  1 each  memory request strobes, held until mem_ready.
REQ-014 mem_addr  out  ADDR_W;  mem_wdata  out  LINE_W;  mem_rdata  in  LINE_W.
REQ-015 mem_ready  in  1  single-cycle memory completion pulse.

Function
REQ-016 SHALL hold up to DEPTH entries {addr, data, valid} in a FIFO with head, tail and count (0..DEPTH).
REQ-017 SHALL implement states IDLE, MRD, MWR, RESP; mem_read=1 only in MRD, mem_write=1 only in MWR, cache_ready=1 only in RESP.
REQ-018 IDLE priority, highest first: cache_read, cache_write, drain (count>0); cache_read and cache_write both high SHALL be treated as a read.
REQ-019 IDLE, cache_read, cache_addr matches a valid entry: load that entry's data into the response register -> RESP (hit: cache_ready in the next cycle).
REQ-020 IDLE, cache_read, no match: latch cache_addr -> MRD; MRD drives mem_addr=latched addr until mem_ready, then loads mem_rdata into the response register -> RESP.
REQ-021 IDLE, cache_write, cache_addr matches a valid entry: overwrite that entry's data in place, count unchanged -> RESP.
REQ-022 IDLE, cache_write, no match, count<DEPTH: enqueue at tail, count+1 -> RESP.
REQ-023 IDLE, cache_write, no match, count==DEPTH: -> MWR without accepting the write; it is retried in IDLE after the drain.
REQ-024 IDLE, no request, count>0: -> MWR.
REQ-025 MWR SHALL drive mem_addr/mem_wdata from the head entry; on mem_ready: invalidate head, head+1 (mod DEPTH), count-1 -> IDLE.
REQ-026 RESP SHALL last exactly one cycle, drive cache_rdata from the response register, then -> IDLE.
REQ-027 At most one entry SHALL ever hold a given address (coalescing); forwarded read data SHALL equal the last accepted write to that address.
REQ-028 mem_addr/mem_wdata SHALL stay stable while mem_read or mem_write is high; outside MRD/MWR they are don't-care but SHALL be driven to 0.
REQ-029 Requests arriving during MRD/MWR/RESP SHALL be ignored until IDLE; a pending MWR always completes first.

Reset
REQ-030 On proc_reset: state IDLE, count/head/tail 0, all valid 0, response register 0; cache_ready, mem_read, mem_write 0 from the next cycle.
REQ-031 Reset mid-MRD or mid-MWR SHALL abandon the transaction; buffered data is lost; a mem_ready arriving afterwards SHALL be ignored.

Structure
REQ-032 Package wb_pkg SHALL hold DEPTH, ADDR_W, LINE_W defaults and the state enum.
REQ-033 Entry storage plus parallel address match SHALL be one sub-module, write_buffer_store (outputs hit, hit_index, full, empty, head entry).

Verification
REQ-034 Write addr 0x0000010 data A, empty buffer -> cache_ready 1 cycle later, count=1, no memory activity until the next idle cycle.
REQ-035 Write 0x0000010 = A, then read 0x0000010 -> cache_ready 1 cycle after the read request, cache_rdata=A, mem_read never asserted.
REQ-036 Writes to 0x1,0x2,0x3,0x4 back-to-back, then write 0x5 -> MWR for 0x1 with mem_wdata of 0x1; after mem_ready, 0x5 accepted, count=4.
REQ-037 Write 0x7 = A, then write 0x7 = B -> count=1; drain issues a single mem_write to 0x7 with data B.
REQ-038 Read 0x9 miss, memory ready after 5 cycles with data C -> mem_read high 5 cycles, cache_ready on the following cycle, cache_rdata=C.
REQ-039 proc_reset asserted during MWR -> next cycle mem_write=0, count=0; a subsequent read of that address goes to memory.

Source files
------------

// File: rtl/write_buffer_pkg.sv
// Shared defaults, FSM state encoding and sizing helper for the write buffer.
package wb_pkg;

    localparam int WB_DEPTH  = 4;
    localparam int WB_ADDR_W = 28;
    localparam int WB_LINE_W = 128;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MRD  = 2'd1,
        ST_MWR  = 2'd2,
        ST_RESP = 2'd3
    } wb_state_e;

    // Occupancy counter must represent 0..depth inclusive.
    function automatic int cnt_width(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/write_buffer_if.sv
// Cache-side and memory-side handshake bundle of the write buffer.
interface write_buffer_if
    import wb_pkg::*;
#(
    parameter int ADDR_W = WB_ADDR_W,
    parameter int LINE_W = WB_LINE_W
) ();

    logic              cache_read;
    logic              cache_write;
    logic [ADDR_W-1:0] cache_addr;
    logic [LINE_W-1:0] cache_wdata;
    logic [LINE_W-1:0] cache_rdata;
    logic              cache_ready;

    logic              mem_read;
    logic              mem_write;
    logic [ADDR_W-1:0] mem_addr;
    logic [LINE_W-1:0] mem_wdata;
    logic [LINE_W-1:0] mem_rdata;
    logic              mem_ready;

    // The write buffer itself.
    modport slave (
        input  cache_read, cache_write, cache_addr, cache_wdata,
        output cache_rdata, cache_ready,
        output mem_read, mem_write, mem_addr, mem_wdata,
        input  mem_rdata, mem_ready
    );

    // The cache plus memory environment around it.
    modport master (
        output cache_read, cache_write, cache_addr, cache_wdata,
        input  cache_rdata, cache_ready,
        input  mem_read, mem_write, mem_addr, mem_wdata,
        output mem_rdata, mem_ready
    );

endinterface

// File: rtl/write_buffer_store.sv
// Circular entry store with a fully parallel address match over valid entries.
module write_buffer_store
    import wb_pkg::*;
#(
    parameter  int DEPTH  = WB_DEPTH,
    parameter  int ADDR_W = WB_ADDR_W,
    parameter  int LINE_W = WB_LINE_W,
    localparam int IDX_W  = $clog2(DEPTH),
    localparam int CNT_W  = cnt_width(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic [LINE_W-1:0] i_wdata,
    input  logic              i_upd,
    input  logic [IDX_W-1:0]  i_upd_idx,
    input  logic              i_enq,
    input  logic              i_deq,
    output logic              o_hit,
    output logic [IDX_W-1:0]  o_hit_idx,
    output logic [LINE_W-1:0] o_hit_data,
    output logic              o_full,
    output logic              o_empty,
    output logic [ADDR_W-1:0] o_head_addr,
    output logic [LINE_W-1:0] o_head_data
);

    logic [DEPTH-1:0]  r_valid;
    logic [ADDR_W-1:0] r_addr [DEPTH];
    logic [LINE_W-1:0] r_data [DEPTH];
    logic [IDX_W-1:0]  r_head;
    logic [IDX_W-1:0]  r_tail;
    logic [CNT_W-1:0]  r_count;

    logic              w_inc;
    logic              w_dec;

    // Coalescing guarantees at most one valid entry matches any address.
    always_comb begin
        o_hit     = 1'b0;
        o_hit_idx = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (r_valid[i] && (r_addr[i] == i_addr)) begin
                o_hit     = 1'b1;
                o_hit_idx = IDX_W'(i);
            end
        end
    end

    assign o_hit_data  = r_data[o_hit_idx];
    assign o_full      = (r_count == CNT_W'(DEPTH));
    assign o_empty     = (r_count == '0);
    assign o_head_addr = r_addr[r_head];
    assign o_head_data = r_data[r_head];

    assign w_inc = i_enq && !o_full;
    assign w_dec = i_deq && !o_empty;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid <= '0;
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            if (w_inc) begin
                r_valid[r_tail] <= 1'b1;
                r_tail          <= r_tail + IDX_W'(1);
            end
            if (w_dec) begin
                r_valid[r_head] <= 1'b0;
                r_head          <= r_head + IDX_W'(1);
            end
            r_count <= r_count + CNT_W'(w_inc) - CNT_W'(w_dec);
        end
    end

    // Payload storage is qualified by r_valid, so it needs no reset.
    always_ff @(posedge clk) begin
        if (w_inc) begin
            r_addr[r_tail] <= i_addr;
            r_data[r_tail] <= i_wdata;
        end
        if (i_upd) begin
            r_data[i_upd_idx] <= i_wdata;
        end
    end

endmodule

// File: rtl/write_buffer.sv
// Coalescing line write buffer between a cache and memory, with read forwarding.
module write_buffer
    import wb_pkg::*;
#(
    parameter int DEPTH  = WB_DEPTH,
    parameter int ADDR_W = WB_ADDR_W,
    parameter int LINE_W = WB_LINE_W
) (
    input  logic           clk,
    input  logic           proc_reset,
    write_buffer_if.slave  wb
);

    localparam int IDX_W = $clog2(DEPTH);

    wb_state_e         r_state;
    logic              r_cache_ready;
    logic              r_mem_read;
    logic              r_mem_write;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [LINE_W-1:0] r_mem_wdata;
    logic [LINE_W-1:0] r_resp;

    logic              w_hit;
    logic [IDX_W-1:0]  w_hit_idx;
    logic [LINE_W-1:0] w_hit_data;
    logic              w_full;
    logic              w_empty;
    logic [ADDR_W-1:0] w_head_addr;
    logic [LINE_W-1:0] w_head_data;
    logic              w_idle;
    logic              w_wr_only;
    logic              w_upd;
    logic              w_enq;
    logic              w_deq;

    // A simultaneous read and write request is serviced as a read.
    assign w_idle    = (r_state == ST_IDLE);
    assign w_wr_only = wb.cache_write && !wb.cache_read;
    assign w_upd     = w_idle && w_wr_only && w_hit;
    assign w_enq     = w_idle && w_wr_only && !w_hit && !w_full;
    assign w_deq     = (r_state == ST_MWR) && wb.mem_ready;

    write_buffer_store #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W),
        .LINE_W (LINE_W)
    ) u_store (
        .clk         (clk),
        .rst         (proc_reset),
        .i_addr      (wb.cache_addr),
        .i_wdata     (wb.cache_wdata),
        .i_upd       (w_upd),
        .i_upd_idx   (w_hit_idx),
        .i_enq       (w_enq),
        .i_deq       (w_deq),
        .o_hit       (w_hit),
        .o_hit_idx   (w_hit_idx),
        .o_hit_data  (w_hit_data),
        .o_full      (w_full),
        .o_empty     (w_empty),
        .o_head_addr (w_head_addr),
        .o_head_data (w_head_data)
    );

    always_ff @(posedge clk) begin
        if (proc_reset) begin
            r_state       <= ST_IDLE;
            r_cache_ready <= 1'b0;
            r_mem_read    <= 1'b0;
            r_mem_write   <= 1'b0;
            r_mem_addr    <= '0;
            r_mem_wdata   <= '0;
            r_resp        <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (wb.cache_read) begin
                        if (w_hit) begin
                            r_resp        <= w_hit_data;
                            r_cache_ready <= 1'b1;
                            r_state       <= ST_RESP;
                        end else begin
                            r_mem_addr <= wb.cache_addr;
                            r_mem_read <= 1'b1;
                            r_state    <= ST_MRD;
                        end
                    end else if (wb.cache_write && (w_hit || !w_full)) begin
                        r_cache_ready <= 1'b1;
                        r_state       <= ST_RESP;
                    end else if (wb.cache_write || !w_empty) begin
                        // Full-buffer writes stall here and retry after one drain.
                        r_mem_addr  <= w_head_addr;
                        r_mem_wdata <= w_head_data;
                        r_mem_write <= 1'b1;
                        r_state     <= ST_MWR;
                    end
                end
                ST_MRD: begin
                    if (wb.mem_ready) begin
                        r_resp        <= wb.mem_rdata;
                        r_mem_read    <= 1'b0;
                        r_mem_addr    <= '0;
                        r_cache_ready <= 1'b1;
                        r_state       <= ST_RESP;
                    end
                end
                ST_MWR: begin
                    if (wb.mem_ready) begin
                        r_mem_write <= 1'b0;
                        r_mem_addr  <= '0;
                        r_mem_wdata <= '0;
                        r_state     <= ST_IDLE;
                    end
                end
                ST_RESP: begin
                    r_cache_ready <= 1'b0;
                    r_state       <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign wb.cache_ready = r_cache_ready;
    assign wb.cache_rdata = r_resp;
    assign wb.mem_read    = r_mem_read;
    assign wb.mem_write   = r_mem_write;
    assign wb.mem_addr    = r_mem_addr;
    assign wb.mem_wdata   = r_mem_wdata;

endmodule

// File: tb/tb_write_buffer.sv
// Self-checking bench for write_buffer: directed table, corner sequences, random traffic.
module tb_write_buffer;
    import wb_pkg::*;

    localparam int OP_W = 0;
    localparam int OP_R = 1;
    localparam int OP_B = 2;

    typedef struct {
        logic [27:0]  a;
        logic [127:0] d;
    } ent_t;

    typedef struct {
        int           op;
        logic [27:0]  addr;
        logic [127:0] wdata;
        logic [127:0] exp_rdata;
        int           exp_count;
        int           exp_memrd;
    } vec_t;

    logic clk = 1'b0;
    logic proc_reset;
    logic rsp_ready = 1'b0;
    logic man_ready = 1'b0;

    int checks = 0;
    int failures = 0;

    ent_t         mq[$];
    logic [127:0] mem_model [logic [27:0]];
    bit           mem_en = 1'b0;
    int           mem_lat = 3;
    int           rd_pulses = 0;

    write_buffer_if #(.ADDR_W(28), .LINE_W(128)) bif ();

    write_buffer #(.DEPTH(4), .ADDR_W(28), .LINE_W(128)) dut (
        .clk        (clk),
        .proc_reset (proc_reset),
        .wb         (bif)
    );

    assign bif.mem_ready = rsp_ready | man_ready;

    always #5 clk = ~clk;

    function automatic logic [127:0] mem_val(input logic [27:0] a);
        return {4{32'hC0DE_0000 ^ {4'h0, a}}};
    endfunction

    function automatic logic [127:0] mem_lookup(input logic [27:0] a);
        if (mem_model.exists(a)) return mem_model[a];
        return mem_val(a);
    endfunction

    function automatic int find_q(input logic [27:0] a);
        foreach (mq[i]) if (mq[i].a == a) return i;
        return -1;
    endfunction

    function automatic int cur_count();
        return int'(dut.u_store.r_count);
    endfunction

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    // Memory: answers each request after a latency, checks drains against the model.
    int           seen = 0;
    int           cur_lat = 1;
    bit           stable = 1'b1;
    logic [27:0]  cap_a;
    logic [127:0] cap_d;
    initial begin
        bif.mem_rdata = '0;
        forever begin
            @(negedge clk);
            rsp_ready = 1'b0;
            if (proc_reset || !mem_en) begin
                seen = 0;
            end else if (bif.mem_read || bif.mem_write) begin
                if (seen == 0) begin
                    cap_a   = bif.mem_addr;
                    cap_d   = bif.mem_wdata;
                    stable  = 1'b1;
                    cur_lat = (mem_lat > 0) ? mem_lat : int'($urandom_range(1, 4));
                end else if (bif.mem_addr !== cap_a || bif.mem_wdata !== cap_d) begin
                    stable = 1'b0;
                end
                seen++;
                if (seen >= cur_lat) begin
                    chk("mem_req_stable", 128'(stable), 128'(1));
                    if (bif.mem_write) begin
                        if (mq.size() == 0) begin
                            chk("drain_from_empty_model", 128'(1), 128'(0));
                        end else begin
                            chk("drain_addr", 128'(bif.mem_addr), 128'(mq[0].a));
                            chk("drain_data", bif.mem_wdata, mq[0].d);
                            void'(mq.pop_front());
                        end
                        mem_model[bif.mem_addr] = bif.mem_wdata;
                    end else begin
                        bif.mem_rdata = mem_lookup(bif.mem_addr);
                        rd_pulses++;
                    end
                    rsp_ready = 1'b1;
                    seen = 0;
                end
            end else begin
                seen = 0;
            end
        end
    end

    task automatic cache_op(input int op, input logic [27:0] a, input logic [127:0] d,
                            output logic [127:0] rdata, output int cyc, output int rdcyc);
        int rd0;
        int idx;
        ent_t e;
        rdata = '0;
        rd0 = rd_pulses;
        bif.cache_read  = (op != OP_W);
        bif.cache_write = (op != OP_R);
        bif.cache_addr  = a;
        bif.cache_wdata = d;
        cyc = 0;
        rdcyc = 0;
        do begin
            @(negedge clk);
            cyc++;
            if (bif.mem_read) rdcyc++;
        end while (!bif.cache_ready && cyc < 200);
        bif.cache_read  = 1'b0;
        bif.cache_write = 1'b0;
        if (!bif.cache_ready) begin
            checks++;
            failures++;
            $display("FAIL op_timeout addr=%h cycles=%0d required=cache_ready", a, cyc);
            return;
        end
        rdata = bif.cache_rdata;
        idx = find_q(a);
        if (op == OP_W) begin
            if (idx >= 0) begin
                e = mq[idx];
                e.d = d;
                mq[idx] = e;
            end else begin
                e.a = a;
                e.d = d;
                mq.push_back(e);
            end
            chk("wr_no_mem_read", 128'(rd_pulses - rd0), 128'(0));
        end else begin
            chk("rd_data", rdata, (idx >= 0) ? mq[idx].d : mem_lookup(a));
            chk("rd_mem_access", 128'(rd_pulses - rd0), 128'((idx >= 0) ? 0 : 1));
        end
        chk("count_vs_model", 128'(cur_count()), 128'(mq.size()));
    endtask

    task automatic wait_drain();
        int n = 0;
        while (cur_count() != 0 && n < 300) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        chk("drain_count", 128'(cur_count()), 128'(0));
        chk("drain_model_empty", 128'(mq.size()), 128'(0));
    endtask

    function automatic vec_t mk(input int op, input logic [27:0] a, input logic [127:0] wd,
                                input logic [127:0] er, input int ec, input int em);
        vec_t v;
        v.op = op; v.addr = a; v.wdata = wd; v.exp_rdata = er; v.exp_count = ec; v.exp_memrd = em;
        return v;
    endfunction

    localparam logic [127:0] DA = {4{32'hAAAA_0001}};
    localparam logic [127:0] DB = {4{32'hBBBB_0002}};
    localparam logic [127:0] D1 = {4{32'h1111_0011}};
    localparam logic [127:0] D2 = {4{32'h2222_0022}};
    localparam logic [127:0] D3 = {4{32'h3333_0033}};
    localparam logic [127:0] D4 = {4{32'h4444_0044}};
    localparam logic [127:0] E3 = {4{32'h3E3E_0E33}};
    localparam logic [127:0] DF = {4{32'hFFFF_00FF}};

    initial begin
        vec_t         vt [14];
        logic [127:0] rd;
        int           cyc;
        int           rdcyc;

        proc_reset      = 1'b1;
        bif.cache_read  = 1'b0;
        bif.cache_write = 1'b0;
        bif.cache_addr  = '0;
        bif.cache_wdata = '0;
        repeat (3) @(negedge clk);

        chk("rst_cache_ready", 128'(bif.cache_ready), 128'(0));
        chk("rst_mem_read", 128'(bif.mem_read), 128'(0));
        chk("rst_mem_write", 128'(bif.mem_write), 128'(0));
        chk("rst_count", 128'(cur_count()), 128'(0));
        chk("rst_rdata", bif.cache_rdata, 128'(0));
        chk("rst_mem_addr", 128'(bif.mem_addr), 128'(0));
        proc_reset = 1'b0;
        mq.delete();

        // Single write into an empty buffer, then the drain it triggers.
        cache_op(OP_W, 28'h10, DA, rd, cyc, rdcyc);
        chk("wr_latency", 128'(cyc), 128'(1));
        chk("wr_count", 128'(cur_count()), 128'(1));
        chk("wr_resp_no_mwr", 128'(bif.mem_write), 128'(0));
        @(negedge clk);
        chk("idle_no_mwr", 128'(bif.mem_write), 128'(0));
        @(negedge clk);
        chk("drain_mwr", 128'(bif.mem_write), 128'(1));
        chk("drain_mwr_addr", 128'(bif.mem_addr), 128'(28'h10));
        chk("drain_mwr_data", bif.mem_wdata, DA);
        repeat (2) @(negedge clk);
        chk("mwr_held", 128'(bif.mem_write), 128'(1));
        chk("mwr_addr_held", 128'(bif.mem_addr), 128'(28'h10));

        // Reset in the middle of the drain; a late mem_ready must be ignored.
        proc_reset = 1'b1;
        @(negedge clk);
        chk("rst_mwr_dropped", 128'(bif.mem_write), 128'(0));
        chk("rst_mwr_count", 128'(cur_count()), 128'(0));
        proc_reset = 1'b0;
        mq.delete();
        man_ready = 1'b1;
        @(negedge clk);
        man_ready = 1'b0;
        @(negedge clk);
        chk("late_ready_mwr", 128'(bif.mem_write), 128'(0));
        chk("late_ready_mrd", 128'(bif.mem_read), 128'(0));
        chk("late_ready_cready", 128'(bif.cache_ready), 128'(0));
        chk("late_ready_count", 128'(cur_count()), 128'(0));

        // Lost write: read goes to memory with 5-cycle latency.
        mem_en = 1'b1;
        mem_lat = 5;
        cache_op(OP_R, 28'h10, '0, rd, cyc, rdcyc);
        chk("miss_data", rd, mem_val(28'h10));
        chk("miss_mem_read_cycles", 128'(rdcyc), 128'(5));
        chk("miss_latency", 128'(cyc), 128'(6));

        // Directed table, issued back to back so no idle drain intervenes.
        mem_lat = 3;
        vt[0]  = mk(OP_W, 28'h10, DA, '0, 1, 0);
        vt[1]  = mk(OP_R, 28'h10, '0, DA, 1, 0);
        vt[2]  = mk(OP_W, 28'h10, DB, '0, 1, 0);
        vt[3]  = mk(OP_R, 28'h10, '0, DB, 1, 0);
        vt[4]  = mk(OP_W, 28'h1, D1, '0, 2, 0);
        vt[5]  = mk(OP_W, 28'h2, D2, '0, 3, 0);
        vt[6]  = mk(OP_W, 28'h3, D3, '0, 4, 0);
        vt[7]  = mk(OP_W, 28'h4, D4, '0, 4, 0);
        vt[8]  = mk(OP_R, 28'h10, '0, DB, 4, 1);
        vt[9]  = mk(OP_R, 28'h99, '0, mem_val(28'h99), 4, 1);
        vt[10] = mk(OP_R, 28'h2, '0, D2, 4, 0);
        vt[11] = mk(OP_W, 28'h3, E3, '0, 4, 0);
        vt[12] = mk(OP_R, 28'h3, '0, E3, 4, 0);
        vt[13] = mk(OP_B, 28'h3, DF, E3, 4, 0);
        for (int i = 0; i < 14; i++) begin
            cache_op(vt[i].op, vt[i].addr, vt[i].wdata, rd, cyc, rdcyc);
            if (vt[i].op != OP_W) chk($sformatf("vec%0d_rdata", i), rd, vt[i].exp_rdata);
            chk($sformatf("vec%0d_count", i), 128'(cur_count()), 128'(vt[i].exp_count));
            chk($sformatf("vec%0d_memrd", i), 128'(rdcyc > 0), 128'(vt[i].exp_memrd));
        end

        wait_drain();
        cache_op(OP_R, 28'h3, '0, rd, cyc, rdcyc);
        chk("post_drain_rdata", rd, E3);
        chk("post_drain_memrd", 128'(rdcyc > 0), 128'(1));

        // Random traffic over a small address pool to exercise hits and coalescing.
        mem_lat = 0;
        for (int n = 0; n < 400; n++) begin
            int op;
            logic [27:0] a;
            op = int'($urandom_range(0, 9));
            op = (op < 5) ? OP_W : ((op < 9) ? OP_R : OP_B);
            a  = 28'($urandom_range(0, 11));
            cache_op(op, a, {$urandom, $urandom, $urandom, $urandom}, rd, cyc, rdcyc);
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end
        wait_drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
